// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake states, data word and arbiter FSM states.
`timescale 1ns/1ps
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_GNT = 2'd1,
    I_GNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// dcache/icache arbiter for the single-ported RAM; one word per grant, dcache priority.
// Define MEMARB_FAIR_EN to let a starved icache take a grant after STARVE_LIMIT dcache grants.
`timescale 1ns/1ps
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [31:0]       iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dstore,
  output logic              dwait,
  output logic [31:0]       dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  arb_state_t state_q, state_d;
  logic       mem_err_q, mem_err_d;
  ramstate_t  rs;
  logic       d_req;
  logic       force_i;

  assign rs    = ramstate_t'(ramstate);
  assign d_req = dREN | dWEN;

`ifdef MEMARB_FAIR_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);
  logic [2:0] starve_q, starve_d;

  assign force_i = iREN && (starve_q == STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && !iREN)
      starve_d = '0;
    else if (state_q == D_GNT && d_req && rs == ACCESS && iREN && starve_q != 3'd7)
      starve_d = starve_q + 3'd1;
    else if (state_q == I_GNT && iREN && rs == ACCESS)
      starve_d = '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign force_i = 1'b0;
`endif

  // RAM controls follow the live request, so a dropped request releases the RAM at once.
  always_comb begin
    state_d   = state_q;
    mem_err_d = mem_err_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    dwait     = 1'b1;
    iwait     = 1'b1;
    case (state_q)
      IDLE: begin
        if (force_i)   state_d = I_GNT;
        else if (d_req) state_d = D_GNT;
        else if (iREN)  state_d = I_GNT;
      end
      D_GNT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramstore = dstore;
          if (rs == ACCESS) begin
            dwait   = 1'b0;
            state_d = IDLE;
          end else if (rs == ERROR) begin
            mem_err_d = 1'b1;
          end
        end
      end
      I_GNT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (rs == ACCESS) begin
            iwait   = 1'b0;
            state_d = IDLE;
          end else if (rs == ERROR) begin
            mem_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
  assign dload   = ramload;
  assign iload   = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized caches/RAM against a grant-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int LIM = 4;
`ifdef MEMARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int EXP_D_BEFORE_I = FAIR ? LIM : 6;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [1:0]  ramstate;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: who owns the RAM (0 none, 1 dcache, 2 icache), starvation tally, sticky error.
  int m_g, m_cnt;
  bit m_err;

  // Stimulus control
  bit rnd_mode, d_hold, d_pend, i_pend, use_fixed, err_once;
  bit pd_ren, pd_wen, pi_ren;
  logic [31:0] pd_addr, pd_data, pi_addr, fixed_load;
  int lat, cur_lat, busy_cnt, d_seen, i_seen;

  // Observation log
  int cyc;
  int d_pulses[$], i_pulses[$], ren_cyc[$];
  logic [31:0] ren_addr[$], ram_addr[$], ram_data[$];
  bit ram_we[$];
  logic [31:0] d_last_load;
  int ren_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_tick();
    logic d_live;
    d_live = dREN | dWEN;
    case (m_g)
      0: begin
        if (!iREN) m_cnt = 0;
        if (FAIR && iREN && m_cnt == LIM) m_g = 2;
        else if (d_live)                 m_g = 1;
        else if (iREN)                   m_g = 2;
      end
      1: begin
        if (!d_live) m_g = 0;
        else if (ramstate == 2'd2) begin
          m_g = 0;
          if (iREN && m_cnt < 7) m_cnt++;
        end else if (ramstate == 2'd3) m_err = 1'b1;
      end
      default: begin
        if (!iREN) m_g = 0;
        else if (ramstate == 2'd2) begin
          m_g = 0;
          m_cnt = 0;
        end else if (ramstate == 2'd3) m_err = 1'b1;
      end
    endcase
  endtask

  task automatic compare();
    logic e_ren, e_wen, e_dw, e_iw;
    cyc++;
    if (!nRST) begin
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_dwait", dwait, 1);
      chk("rst_iwait", iwait, 1);
      chk("rst_mem_err", mem_err, 0);
    end else begin
      e_ren = 0; e_wen = 0; e_dw = 1; e_iw = 1;
      if (m_g == 1 && (dREN | dWEN)) begin
        e_wen = dWEN;
        e_ren = dREN & ~dWEN;
        e_dw  = (ramstate != 2'd2);
      end
      if (m_g == 2 && iREN) begin
        e_ren = 1;
        e_iw  = (ramstate != 2'd2);
      end
      chk("ramREN", ramREN, e_ren);
      chk("ramWEN", ramWEN, e_wen);
      chk("dwait", dwait, e_dw);
      chk("iwait", iwait, e_iw);
      chk("mem_err", mem_err, m_err);
      if (e_ren | e_wen) chk("ramaddr", ramaddr, (m_g == 1) ? daddr : iaddr);
      if (e_wen) chk("ramstore", ramstore, dstore);
      if (!e_dw) chk("dload", dload, ramload);
      if (!e_iw) chk("iload", iload, ramload);
      if (!dwait) begin d_pulses.push_back(cyc); d_last_load = dload; end
      if (!iwait) i_pulses.push_back(cyc);
      if (ramREN) begin ren_cnt++; ren_cyc.push_back(cyc); ren_addr.push_back(ramaddr); end
      if (ramstate == 2'd2 && (ramREN || ramWEN)) begin
        ram_we.push_back(ramWEN);
        ram_addr.push_back(ramaddr);
        ram_data.push_back(ramWEN ? ramstore : 32'h0);
      end
    end
  endtask

  // One clock: model at the edge, caches at +1, RAM reacts at +2, check on the falling edge.
  task automatic step();
    int k;
    @(posedge CLK);
    if (!nRST) begin m_g = 0; m_cnt = 0; m_err = 0; end
    else model_tick();
    #1;
    if (d_pulses.size() != d_seen) begin
      d_seen = d_pulses.size();
      if (!d_hold) begin dREN = 0; dWEN = 0; end
    end
    if (d_pend) begin
      dREN = pd_ren; dWEN = pd_wen; daddr = pd_addr; dstore = pd_data; d_pend = 0;
    end else if (rnd_mode && !(dREN || dWEN) && $urandom_range(0, 2) == 0) begin
      k = int'($urandom_range(0, 2));
      dREN = (k != 1); dWEN = (k != 0);
      daddr = $urandom; dstore = $urandom;
    end
    if (i_pulses.size() != i_seen) begin
      i_seen = i_pulses.size();
      iREN = 0;
    end
    if (i_pend) begin
      iREN = pi_ren; iaddr = pi_addr; i_pend = 0;
    end else if (rnd_mode && !iREN && $urandom_range(0, 2) == 0) begin
      iREN = 1; iaddr = $urandom;
    end
    #1;
    ramload = use_fixed ? fixed_load : $urandom;
    if (nRST && (ramREN || ramWEN)) begin
      if (err_once) begin ramstate = 2'd3; err_once = 0; end
      else if (rnd_mode && $urandom_range(0, 15) == 0) ramstate = 2'd3;
      else if (busy_cnt < cur_lat) begin ramstate = 2'd1; busy_cnt++; end
      else begin
        ramstate = 2'd2; busy_cnt = 0;
        cur_lat = rnd_mode ? int'($urandom_range(0, 3)) : lat;
      end
    end else begin
      ramstate = 2'd0; busy_cnt = 0;
    end
    @(negedge CLK);
    compare();
  endtask

  task automatic set_d(input bit ren, input bit wen, input logic [31:0] a, input logic [31:0] d);
    pd_ren = ren; pd_wen = wen; pd_addr = a; pd_data = d; d_pend = 1;
  endtask

  task automatic set_i(input bit ren, input logic [31:0] a);
    pi_ren = ren; pi_addr = a; i_pend = 1;
  endtask

  task automatic set_lat(input int l);
    lat = l; cur_lat = l; busy_cnt = 0;
  endtask

  task automatic do_reset();
    nRST = 0;
    dREN = 0; dWEN = 0; iREN = 0; d_pend = 0; i_pend = 0; d_hold = 0;
    m_g = 0; m_cnt = 0; m_err = 0;
    step(); step();
    nRST = 1;
  endtask

  task automatic run_until_d(input int n0, input int budget);
    for (int n = 0; n < budget && d_pulses.size() == n0; n++) step();
  endtask

  initial begin
    int ds0, is0, r0, q0, nb, first_i;
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
    rnd_mode = 0; d_hold = 0; d_pend = 0; i_pend = 0; use_fixed = 0; err_once = 0;
    fixed_load = 0; d_seen = 0; i_seen = 0; cyc = 0; ren_cnt = 0;
    m_g = 0; m_cnt = 0; m_err = 0;
    set_lat(1);

    #3;
    chk("init_ramREN", ramREN, 0);
    chk("init_ramWEN", ramWEN, 0);
    chk("init_dwait", dwait, 1);
    chk("init_iwait", iwait, 1);
    chk("init_ramaddr", ramaddr, 0);
    chk("init_ramstore", ramstore, 0);
    chk("init_mem_err", mem_err, 0);
    do_reset();

    // Single dcache read, two BUSY cycles before ACCESS
    set_lat(2); use_fixed = 1; fixed_load = 32'hDEADBEEF;
    ds0 = d_pulses.size(); is0 = i_pulses.size(); r0 = ren_cnt;
    set_d(1, 0, 32'h100, 0);
    run_until_d(ds0, 20);
    step(); step();
    chk("rd_dwait_pulses", d_pulses.size() - ds0, 1);
    chk("rd_ramREN_cycles", ren_cnt - r0, 3);
    chk("rd_dload", d_last_load, 32'hDEADBEEF);
    chk("rd_iwait_pulses", i_pulses.size() - is0, 0);
    use_fixed = 0;

    // Collision: dcache write and icache read arrive together
    set_lat(1);
    ds0 = d_pulses.size(); is0 = i_pulses.size(); q0 = ram_addr.size(); r0 = ren_cyc.size();
    set_d(0, 1, 32'h3100, 32'h5);
    set_i(1, 32'h40);
    for (int n = 0; n < 30 && i_pulses.size() == is0; n++) step();
    chk("col_ram_txns", ram_addr.size() - q0, 2);
    if (ram_addr.size() >= q0 + 2) begin
      chk("col_first_addr", ram_addr[q0], 32'h3100);
      chk("col_first_we", ram_we[q0], 1);
      chk("col_first_data", ram_data[q0], 32'h5);
      chk("col_second_addr", ram_addr[q0 + 1], 32'h40);
      chk("col_second_we", ram_we[q0 + 1], 0);
    end
    first_i = -1;
    for (int k = r0; k < ren_cyc.size(); k++)
      if (first_i < 0 && ren_addr[k] == 32'h40) first_i = ren_cyc[k];
    if (d_pulses.size() > ds0) chk("col_i_issue_cycle", first_i, d_pulses[ds0] + 2);
    step(); step();

    // Both enables: write wins, no read strobe
    r0 = ren_cnt; q0 = ram_addr.size(); ds0 = d_pulses.size();
    set_d(1, 1, 32'h55, 32'hABCD);
    run_until_d(ds0, 20);
    chk("both_ramREN_cycles", ren_cnt - r0, 0);
    if (ram_we.size() > q0) chk("both_we", ram_we[q0], 1);
    step(); step();

    // Request dropped mid-grant: RAM released, no wait pulse
    set_lat(3); ds0 = d_pulses.size();
    set_d(1, 0, 32'h99, 0);
    step(); step();
    chk("drop_ramREN_before", ramREN, 1);
    set_d(0, 0, 32'h99, 0);
    step();
    chk("drop_ramREN_after", ramREN, 0);
    step(); step(); step();
    chk("drop_no_pulse", d_pulses.size() - ds0, 0);

    // Reset in the middle of a BUSY grant
    set_lat(3); ds0 = d_pulses.size();
    set_d(1, 0, 32'h180, 0);
    step(); step();
    nRST = 0; m_g = 0; m_cnt = 0; m_err = 0;
    #1;
    chk("rstmid_ramREN", ramREN, 0);
    chk("rstmid_ramWEN", ramWEN, 0);
    chk("rstmid_dwait", dwait, 1);
    step();
    nRST = 1;
    #1;
    chk("rstmid_idle_ramREN", ramREN, 0);
    run_until_d(ds0, 20);
    chk("rstmid_complete", d_pulses.size() - ds0, 1);
    step(); step();

    // Starvation: dcache holds its request continuously while icache waits
    do_reset(); set_lat(1);
    ds0 = d_pulses.size(); is0 = i_pulses.size();
    d_hold = 1;
    set_d(1, 0, 32'h200, 0);
    set_i(1, 32'h300);
    for (int n = 0; n < 120 && i_pulses.size() == is0; n++) begin
      if (d_pulses.size() - ds0 >= 6 && dREN && !d_pend) begin
        set_d(0, 0, 32'h200, 0);
        d_hold = 0;
      end
      step();
    end
    chk("fair_i_done", i_pulses.size() - is0, 1);
    nb = 0;
    if (i_pulses.size() > is0)
      for (int k = ds0; k < d_pulses.size(); k++)
        if (d_pulses[k] < i_pulses[is0]) nb++;
    chk("fair_d_before_i", nb, EXP_D_BEFORE_I);
    d_hold = 0;
    set_d(0, 0, 0, 0);
    repeat (4) step();

    // ERROR once then ACCESS: sticky error flag, single completion
    do_reset(); set_lat(0);
    chk("err_clear_after_reset", mem_err, 0);
    ds0 = d_pulses.size();
    err_once = 1;
    set_d(1, 0, 32'h77, 0);
    run_until_d(ds0, 20);
    chk("err_mem_err", mem_err, 1);
    chk("err_single_pulse", d_pulses.size() - ds0, 1);
    repeat (5) step();
    chk("err_sticky", mem_err, 1);

    // Randomized traffic from both caches against a randomized RAM
    do_reset();
    rnd_mode = 1; cur_lat = 1;
    repeat (3000) step();
    rnd_mode = 0; set_lat(0);
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
